// File: rtl/fake_tx_pkg.sv
// Shared types, widths and helpers for the fake AD9364 TX sink.
package fake_tx_pkg;

    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned IQ_W     = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    typedef struct packed {
        logic [IQ_W-1:0] i;
        logic [IQ_W-1:0] q;
    } iq_sample_t;

    function automatic logic [IQ_W-1:0] exp_q_of(input logic [IQ_W-1:0] i);
        return ~i;
    endfunction

    // Magnitude of a two's complement value; the most negative code saturates.
    function automatic logic [IQ_W-1:0] abs_sat(input logic [IQ_W-1:0] x);
        if (!x[IQ_W-1]) begin
            return x;
        end
        if (x == {1'b1, {(IQ_W-1){1'b0}}}) begin
            return {1'b0, {(IQ_W-1){1'b1}}};
        end
        return ~x + 1'b1;
    endfunction

endpackage

// File: rtl/fake_tx_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module fake_tx_sat_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ad9364_fake_tx_sink.sv
// Fake AD9364 DAC sink: drains the TX FIFO and checks the host counter pattern.
// Optional FAKE_TX_PEAK_EN adds running |I|/|Q| peak outputs.
module ad9364_fake_tx_sink
    import fake_tx_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 16,
    parameter int unsigned MAX_MISS   = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                l_clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                tx_read_allowed,
    output logic                dac_read_en,
    input  logic [SAMPLE_W-1:0] dac_data,
    input  logic                clear_stats,
    output logic                tx_enable,
    output logic                locked,
    output logic [CNT_W-1:0]    sample_count,
    output logic [CNT_W-1:0]    error_count,
    output logic [CNT_W-1:0]    underrun_count,
    output logic [SAMPLE_W-1:0] last_sample
`ifdef FAKE_TX_PEAK_EN
    ,
    output logic [IQ_W-1:0]     peak_i,
    output logic [IQ_W-1:0]     peak_q
`endif
);

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W  = $clog2(MAX_MISS + 1);

    (* ASYNC_REG = "TRUE" *) logic enable_meta_q;
    (* ASYNC_REG = "TRUE" *) logic enable_sync_q;

    logic                rd_d1_q;
    state_e              state_q,  state_d;
    logic [MATCH_W-1:0]  match_q,  match_d;
    logic [MISS_W-1:0]   miss_q,   miss_d;
    logic                seed_q,   seed_d;
    logic [IQ_W-1:0]     exp_i_q,  exp_i_d;
    logic [SAMPLE_W-1:0] last_q,   last_d;
    logic                locked_q, locked_d;

    iq_sample_t rx;
    logic       sample_ok;
    logic       err_inc;
    logic       underrun_inc;

    assign dac_read_en = enable_sync_q & tx_read_allowed;
    assign tx_enable   = dac_read_en;

    assign rx        = iq_sample_t'(dac_data);
    assign sample_ok = (rx.i == exp_i_q) && (rx.q == exp_q_of(exp_i_q));

    // Pattern tracker: every valid word reseeds the expected I, compared or not.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        miss_d  = miss_q;
        seed_d  = seed_q;
        exp_i_d = exp_i_q;
        last_d  = last_q;
        err_inc = 1'b0;

        if (rd_d1_q) begin
            last_d  = dac_data;
            exp_i_d = rx.i + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable_sync_q) begin
                    state_d = ACQUIRE;
                    seed_d  = 1'b1;
                    match_d = '0;
                    miss_d  = '0;
                end
            end
            ACQUIRE: begin
                if (rd_d1_q) begin
                    if (seed_q) begin
                        seed_d = 1'b0;
                    end else if (sample_ok) begin
                        match_d = match_q + 1'b1;
                        if (match_d == MATCH_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (rd_d1_q) begin
                    if (sample_ok) begin
                        miss_d = '0;
                    end else begin
                        err_inc = 1'b1;
                        miss_d  = miss_q + 1'b1;
                        if (miss_d == MISS_W'(MAX_MISS)) begin
                            state_d = ACQUIRE;
                            match_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Loss of enable wins, but the in-flight sample above is still processed.
        if (!enable_sync_q) begin
            state_d = IDLE;
            match_d = '0;
            miss_d  = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge l_clk) begin
        if (rst) begin
            enable_meta_q <= 1'b0;
            enable_sync_q <= 1'b0;
            rd_d1_q       <= 1'b0;
            state_q       <= IDLE;
            match_q       <= '0;
            miss_q        <= '0;
            seed_q        <= 1'b0;
            exp_i_q       <= '0;
            last_q        <= '0;
            locked_q      <= 1'b0;
        end else begin
            enable_meta_q <= enable;
            enable_sync_q <= enable_meta_q;
            rd_d1_q       <= dac_read_en;
            state_q       <= state_d;
            match_q       <= match_d;
            miss_q        <= miss_d;
            seed_q        <= seed_d;
            exp_i_q       <= exp_i_d;
            last_q        <= last_d;
            locked_q      <= locked_d;
        end
    end

    assign underrun_inc = enable_sync_q & ~tx_read_allowed & (state_q == LOCKED);

    fake_tx_sat_cnt #(.CNT_W(CNT_W)) u_sample_cnt (
        .clk   (l_clk),
        .rst   (rst),
        .inc   (rd_d1_q),
        .clr   (clear_stats),
        .count (sample_count)
    );

    fake_tx_sat_cnt #(.CNT_W(CNT_W)) u_error_cnt (
        .clk   (l_clk),
        .rst   (rst),
        .inc   (err_inc),
        .clr   (clear_stats),
        .count (error_count)
    );

    fake_tx_sat_cnt #(.CNT_W(CNT_W)) u_underrun_cnt (
        .clk   (l_clk),
        .rst   (rst),
        .inc   (underrun_inc),
        .clr   (clear_stats),
        .count (underrun_count)
    );

    assign locked      = locked_q;
    assign last_sample = last_q;

`ifdef FAKE_TX_PEAK_EN
    logic [IQ_W-1:0] peak_i_q, peak_i_d;
    logic [IQ_W-1:0] peak_q_q, peak_q_d;
    logic [IQ_W-1:0] abs_i, abs_q;

    // Running magnitude peaks over valid samples.
    always_comb begin
        abs_i    = abs_sat(rx.i);
        abs_q    = abs_sat(rx.q);
        peak_i_d = peak_i_q;
        peak_q_d = peak_q_q;
        if (clear_stats) begin
            peak_i_d = '0;
            peak_q_d = '0;
        end else if (rd_d1_q) begin
            if (abs_i > peak_i_q) begin
                peak_i_d = abs_i;
            end
            if (abs_q > peak_q_q) begin
                peak_q_d = abs_q;
            end
        end
    end

    always_ff @(posedge l_clk) begin
        if (rst) begin
            peak_i_q <= '0;
            peak_q_q <= '0;
        end else begin
            peak_i_q <= peak_i_d;
            peak_q_q <= peak_q_d;
        end
    end

    assign peak_i = peak_i_q;
    assign peak_q = peak_q_q;
`endif

endmodule

// File: tb/tb_ad9364_fake_tx_sink.sv
// Bench for ad9364_fake_tx_sink: FIFO model feeding a last_sample scoreboard,
// table-driven pattern phases and hand-written corner sequences.
module tb_ad9364_fake_tx_sink;

    logic        l_clk;
    logic        rst;
    logic        enable;
    logic        tx_read_allowed;
    logic        dac_read_en;
    logic [23:0] dac_data;
    logic        clear_stats;
    logic        tx_enable;
    logic        locked;
    logic [31:0] sample_count;
    logic [31:0] error_count;
    logic [31:0] underrun_count;
    logic [23:0] last_sample;
`ifdef FAKE_TX_PEAK_EN
    logic [11:0] peak_i;
    logic [11:0] peak_q;
`endif

    ad9364_fake_tx_sink dut (
        .l_clk           (l_clk),
        .rst             (rst),
        .enable          (enable),
        .tx_read_allowed (tx_read_allowed),
        .dac_read_en     (dac_read_en),
        .dac_data        (dac_data),
        .clear_stats     (clear_stats),
        .tx_enable       (tx_enable),
        .locked          (locked),
        .sample_count    (sample_count),
        .error_count     (error_count),
        .underrun_count  (underrun_count),
        .last_sample     (last_sample)
`ifdef FAKE_TX_PEAK_EN
        ,
        .peak_i          (peak_i),
        .peak_q          (peak_q)
`endif
    );

    initial l_clk = 1'b0;
    always #5 l_clk = ~l_clk;

    typedef struct {
        int unsigned start_i;
        int unsigned n;
        bit          corrupt;
        bit          clear;
        bit          exp_locked;
        int unsigned exp_err;
        int unsigned exp_samples;
    } vec_t;

    vec_t        vecs [7];
    logic [23:0] fifo [$];
    logic [23:0] sb   [$];
    bit          pending;
    int          n_checks;
    int          n_fail;

    function automatic logic [23:0] mk_word(input logic [11:0] i, input bit corrupt);
        logic [11:0] q;
        q = ~i;
        if (corrupt) q = q ^ 12'h001;
        return {i, q};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [23:0] w);
        fifo.push_back(w);
        tx_read_allowed = 1'b1;
    endtask

    // One clock: serve FIFO reads and score the word processed on this edge.
    task automatic step();
        logic        rd_now;
        bit          proc_now;
        logic [23:0] w;
        @(negedge l_clk);
        rd_now   = dac_read_en;
        proc_now = pending;
        @(posedge l_clk);
        #1;
        if (rst) begin
            sb.delete();
            fifo.delete();
            pending = 1'b0;
        end else begin
            if (proc_now) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    w = sb.pop_front();
                    check("last_sample", 32'(last_sample), 32'(w));
                end
            end
            pending = rd_now;
            if (rd_now) begin
                if (fifo.size() == 0) begin
                    check("fifo_overread", 32'd1, 32'd0);
                end else begin
                    w = fifo.pop_front();
                    dac_data = w;
                    sb.push_back(w);
                end
            end
        end
        tx_read_allowed = (fifo.size() != 0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((fifo.size() != 0 || pending) && guard < 20000) begin
            step();
            guard++;
        end
        if (guard >= 20000) check("drain_timeout", 32'(guard), 32'd0);
        check("scoreboard_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        pending         = 1'b0;
        rst             = 1'b1;
        enable          = 1'b0;
        tx_read_allowed = 1'b0;
        dac_data        = '0;
        clear_stats     = 1'b0;

        vecs[0] = '{32'h000, 17,   1'b0, 1'b0, 1'b1, 0, 17};
        vecs[1] = '{32'h011, 4077, 1'b0, 1'b0, 1'b1, 0, 4094};
        vecs[2] = '{32'hFFE, 4,    1'b0, 1'b0, 1'b1, 0, 4098};
        vecs[3] = '{32'h002, 1,    1'b1, 1'b0, 1'b1, 1, 4099};
        vecs[4] = '{32'h003, 2,    1'b0, 1'b0, 1'b1, 1, 4101};
        vecs[5] = '{32'h005, 4,    1'b1, 1'b1, 1'b0, 4, 4};
        vecs[6] = '{32'h009, 16,   1'b0, 1'b0, 1'b1, 4, 20};

        repeat (3) step();
        check("rst_dac_read_en", 32'(dac_read_en), 32'd0);
        check("rst_tx_enable", 32'(tx_enable), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_sample_count", sample_count, 32'd0);
        check("rst_error_count", error_count, 32'd0);
        check("rst_underrun_count", underrun_count, 32'd0);
        check("rst_last_sample", 32'(last_sample), 32'd0);
        rst    = 1'b0;
        enable = 1'b1;

        for (int k = 0; k < 7; k++) begin
            if (vecs[k].clear) begin
                clear_stats = 1'b1;
                step();
                clear_stats = 1'b0;
            end
            for (int j = 0; j < int'(vecs[k].n); j++) begin
                push(mk_word(12'(vecs[k].start_i + 32'(j)), vecs[k].corrupt));
            end
            drain();
            check($sformatf("vec%0d_locked", k), 32'(locked), 32'(vecs[k].exp_locked));
            check($sformatf("vec%0d_error_count", k), error_count, vecs[k].exp_err);
            check($sformatf("vec%0d_sample_count", k), sample_count, vecs[k].exp_samples);
        end

        // Underrun while locked with an empty FIFO.
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("underrun_rd_en_%0d", c), 32'(dac_read_en), 32'd0);
        end
        check("underrun_count", underrun_count, 32'd10);
        check("underrun_sample_frozen", sample_count, 32'd0);
        check("underrun_locked", 32'(locked), 32'd1);

        // Clear on the same edge as a mismatched valid sample.
        push(mk_word(12'h019, 1'b1));
        step();
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        check("clr_sample_count", sample_count, 32'd0);
        check("clr_error_count", error_count, 32'd0);
        check("clr_underrun_count", underrun_count, 32'd0);
        check("clr_locked_held", 32'(locked), 32'd1);

        enable = 1'b0;
        repeat (3) step();
        check("disable_locked", 32'(locked), 32'd0);
        check("disable_rd_en", 32'(dac_read_en), 32'd0);

        // Reset with a read in flight.
        enable = 1'b1;
        repeat (3) step();
        push(mk_word(12'h100, 1'b0));
        push(mk_word(12'h101, 1'b0));
        push(mk_word(12'h102, 1'b0));
        step();
        check("midrst_pending", 32'(pending), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_sample_count", sample_count, 32'd0);
        check("midrst_last_sample", 32'(last_sample), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_rd_en", 32'(dac_read_en), 32'd0);

        push(mk_word(12'h800, 1'b0));
        push(mk_word(12'h801, 1'b0));
        drain();
        check("final_sample_count", sample_count, 32'd2);
`ifdef FAKE_TX_PEAK_EN
        check("peak_i", 32'(peak_i), 32'd2047);
        check("peak_q", 32'(peak_q), 32'd2047);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
